ex_div: RTL

- Iterative restoring divider in the EX stage, directly downstream of the ID/EX pipeline register.
- Consumes the registered operands ex_reg1/ex_reg2 for DIV/DIVU and produces {remainder, quotient} for the HI/LO write path.
- The EX stage holds start high and raises its stall request while busy_o is set.
- One radix-2 step per cycle; result handshake via ready_o.

---
 rtl/ex_div.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ex_div.sv
// Iterative radix-2 restoring divider for the EX stage: DIV/DIVU -> {remainder, quotient}.
// Optional build macro DIV_EARLY_OUT_EN: finish immediately when |dividend| < |divisor|.
module ex_div #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  signed_div_i,
  input  logic [DATA_W-1:0]     opdata1_i,
  input  logic [DATA_W-1:0]     opdata2_i,
  input  logic                  annul_i,
  output logic [2*DATA_W-1:0]   result_o,
  output logic                  ready_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*DATA_W-1:0]   work_q, work_d;
  logic [DATA_W-1:0]     divisor_q, divisor_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;
  logic [2*DATA_W-1:0]   result_d;
  logic                  ready_d, busy_d;

  logic [DATA_W-1:0]     abs1, abs2, quo, rem;
  logic [DATA_W:0]       diff;
  logic [2*DATA_W-1:0]   work_step;

  assign abs1 = (signed_div_i && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
  assign abs2 = (signed_div_i && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

  // Partial remainder with the next dividend bit appended, against the divisor.
  assign diff      = work_q[2*DATA_W-1:DATA_W-1] - {1'b0, divisor_q};
  assign work_step = diff[DATA_W] ? {work_q[2*DATA_W-2:0], 1'b0}
                                  : {diff[DATA_W-1:0], work_q[DATA_W-2:0], 1'b1};
  assign quo = neg_quo_q ? -work_step[DATA_W-1:0] : work_step[DATA_W-1:0];
  assign rem = neg_rem_q ? -work_step[2*DATA_W-1:DATA_W] : work_step[2*DATA_W-1:DATA_W];

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_o;
    ready_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = S_BYZERO;
          end
`ifdef DIV_EARLY_OUT_EN
          else if (abs1 < abs2) begin
            state_d  = S_END;
            result_d = {opdata1_i, {DATA_W{1'b0}}};
          end
`endif
          else begin
            state_d   = S_ON;
            work_d    = {{DATA_W{1'b0}}, abs1};
            divisor_d = abs2;
            neg_quo_d = signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_rem_d = signed_div_i && opdata1_i[DATA_W-1];
            cnt_d     = '0;
          end
        end
      end
      S_BYZERO: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = '0;
          state_d  = S_END;
        end
      end
      S_ON: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else begin
          work_d = work_step;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) begin
            result_d = {rem, quo};
            state_d  = S_END;
          end
        end
      end
      S_END: begin
        if (annul_i) begin
          state_d = S_IDLE;
        end else if (start_i) begin
          ready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_ON) || (state_d == S_BYZERO);
  end

  // NOTE: the datapath registers are reset too, so a divide never starts from X state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_o  <= '0;
      ready_o   <= 1'b0;
      busy_o    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_o  <= result_d;
      ready_o   <= ready_d;
      busy_o    <= busy_d;
    end
  end

endmodule
